input_cmd_arbiter: RTL

- Merges the PS/2 letter stream and the four game push buttons (up, down, go, pause) into one ordered command stream for the game state machine.
- Filters repeated make codes and break codes from the keyboard path, and synchronises and debounces the buttons.
- Arbitrates simultaneous requests by fixed priority and buffers them in a small FIFO with a valid/ready handshake.
- Sits between PS2_driver plus the board buttons and the game controller FSM.

---
 rtl/input_cmd_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/input_cmd_arbiter.sv
// rtl/input_cmd_arbiter.sv - merges keyboard letters and debounced buttons into one prioritised command FIFO
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   alph[5:0]          held PS/2 code: 1..52 letter, 53 break, 55 lshift
//   btn_up/down/go/pause  raw asynchronous active-high buttons
//   cmd_ready          consumer takes the head entry this cycle
//   cmd_valid          FIFO non-empty
//   cmd_code[2:0]      head command: 0 CHAR, 1 UP, 2 DOWN, 3 GO, 4 PAUSE
//   cmd_char[5:0]      letter for CHAR entries, else 0
//   fifo_count         current occupancy
//   overflow           sticky: a pending CHAR was replaced before enqueue
module input_cmd_arbiter #(
    parameter int FIFO_DEPTH      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [5:0]                    alph,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_go,
    input  logic                          btn_pause,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [2:0]                    cmd_code,
    output logic [5:0]                    cmd_char,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] C_CHAR  = 3'd0;
    localparam logic [2:0] C_UP    = 3'd1;
    localparam logic [2:0] C_DOWN  = 3'd2;
    localparam logic [2:0] C_GO    = 3'd3;
    localparam logic [2:0] C_PAUSE = 3'd4;

    // ---------------- key path ----------------
    logic [5:0] pre_alph;
    logic       is_letter;
    logic       char_req;

    assign is_letter = (alph != 6'd0) && (alph <= 6'd52);
    assign char_req  = is_letter && (alph != pre_alph);

    // ---------------- button path ----------------
    // bit order: 0 up, 1 down, 2 go, 3 pause
    logic [3:0]    btn_raw;
    logic [3:0]    sync1, sync2, db, db_prev;
    logic [CW-1:0] db_cnt [4];
    logic [3:0]    btn_req;

    assign btn_raw = {btn_pause, btn_go, btn_down, btn_up};
    assign btn_req = db & ~db_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            db_prev <= db;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // ---------------- pending flags and arbitration ----------------
    logic       p_char, p_up, p_down, p_go, p_pause;
    logic [5:0] p_char_val;
    logic       g_char, g_up, g_down, g_go, g_pause;
    logic       pop, push;
    logic [2:0] push_code;
    logic [5:0] push_char;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    mem_code [FIFO_DEPTH];
    logic [5:0]    mem_char [FIFO_DEPTH];

    assign cmd_valid = (fifo_count != '0);
    assign pop       = cmd_valid && cmd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = (p_pause | p_go | p_char | p_up | p_down) &&
                       ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);

    always_comb begin
        g_pause   = 1'b0;
        g_go      = 1'b0;
        g_char    = 1'b0;
        g_up      = 1'b0;
        g_down    = 1'b0;
        push_code = C_CHAR;
        push_char = 6'd0;
        if (push) begin
            if (p_pause) begin
                g_pause   = 1'b1;
                push_code = C_PAUSE;
            end else if (p_go) begin
                g_go      = 1'b1;
                push_code = C_GO;
            end else if (p_char) begin
                g_char    = 1'b1;
                push_code = C_CHAR;
                push_char = p_char_val;
            end else if (p_up) begin
                g_up      = 1'b1;
                push_code = C_UP;
            end else begin
                g_down    = 1'b1;
                push_code = C_DOWN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_alph   <= '0;
            p_char     <= 1'b0;
            p_char_val <= '0;
            p_up       <= 1'b0;
            p_down     <= 1'b0;
            p_go       <= 1'b0;
            p_pause    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (char_req) begin
                pre_alph <= alph;
            end else if (alph == 6'd53 || alph == 6'd55) begin
                pre_alph <= '0;
            end

            if (char_req) begin
                p_char     <= 1'b1;
                p_char_val <= alph;
                // Only a letter that is still waiting (not leaving now) is lost.
                if (p_char && !g_char) overflow <= 1'b1;
            end else if (g_char) begin
                p_char <= 1'b0;
            end

            p_up    <= (p_up    & ~g_up)    | btn_req[0];
            p_down  <= (p_down  & ~g_down)  | btn_req[1];
            p_go    <= (p_go    & ~g_go)    | btn_req[2];
            p_pause <= (p_pause & ~g_pause) | btn_req[3];
        end
    end

    // ---------------- FWFT FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_code[wr_ptr] <= push_code;
            mem_char[wr_ptr] <= push_char;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    // Head fields read as zero while empty so reset and drain look clean.
    assign cmd_code = cmd_valid ? mem_code[rd_ptr] : 3'd0;
    assign cmd_char = cmd_valid ? mem_char[rd_ptr] : 6'd0;

endmodule
